pic_in_service_control: RTL
===========================

Name: pic_in_service_control

Overview:
- Downstream stage of the priority resolver in the 8259A-style PIC.
- Consumes the resolver's chosen interrupt and raises INT toward the CPU. Runs the two-pulse INTA acknowledge sequence, maintains the In-Service Register (ISR) and drives the 8086-mode vector byte.
- Handles normal EOI, specific EOI, rotating EOI and AEOI.
- Feeds IRR-bit clears and rotation updates back to the IRR and resolver.

Parameters:
- NUM_IRQ, 8, number of request lines. Only 8 is supported; level encoding is 3 bits.
- VEC_BASE_W, 5, width of the ICW2 vector base field T7..T3.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- irr  in  8  pending requests from the IRR, after masking.
- chosen_interrupt  in  3  resolver's winning level.
- chosen_valid  in  1  high when irr is non-zero.
- lowest_priority  in  3  current lowest-priority level: 7 in fully nested mode, rotating otherwise.
- aeoi  in  1  automatic-EOI mode (ICW4).
- rotate_aeoi  in  1  rotate on AEOI (OCW2 set-rotate-in-AEOI).
- vector_base  in  5  ICW2 T7..T3.
- inta_pulse  in  1  one-cycle pulse per synchronized INTA falling edge.
- eoi_valid  in  1  one-cycle OCW2 EOI command strobe.
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific.
- eoi_level  in  3  level for specific EOI.
- eoi_rotate  in  1  rotate on this EOI.
- int_out  out  1  interrupt request to the CPU.
- isr  out  8  In-Service Register.
- irr_clear  out  8  one-hot, one-cycle clear of the acknowledged IRR bit.
- resolver_clear  out  1  one-cycle pulse, coincident with irr_clear.
- data_out  out  8  vector byte.
- data_out_en  out  1  vector byte valid.
- rotate_update  out  1  one-cycle pulse; resolver loads a new lowest priority.
- rotate_lowest  out  3  new lowest-priority level, valid with rotate_update.

Behaviour:
- Reset (async, reset=0): all outputs are 0; FSM is in IDLE; latched level is 0.
- Priority rank of level n is (n - lowest_priority - 1) mod 8. Rank 0 is highest. All arithmetic is 3-bit wrap-around.
- Highest in-service level is the set ISR bit with the smallest rank. None exists when isr == 0.

int_out (registered):
- Next value is 1 when all of the following hold:
  - FSM is in IDLE;
  - chosen_valid = 1;
  - isr == 0, or rank(chosen_interrupt) < rank of the highest in-service level.
- Otherwise the next value is 0.
- Equal rank (already in service) does not raise INT.

FSM states: IDLE, ACK1.

IDLE, on inta_pulse:
- Latch L = chosen_interrupt if int_out = 1. Otherwise this is a spurious acknowledge: L = 7, no ISR set, no irr_clear.
- Non-spurious case, next cycle:
  - isr[L] = 1;
  - irr_clear = 1 << L for one cycle;
  - resolver_clear = 1 for one cycle.
- int_out drops the next cycle.
- Go to ACK1.
- data_out_en stays 0 on the first pulse.

ACK1, on inta_pulse:
- Next cycle: data_out = {vector_base, L} and data_out_en = 1 for exactly one cycle.
- If aeoi = 1 and not spurious: isr[L] clears in that same cycle.
- If rotate_aeoi is also 1: rotate_update pulses with rotate_lowest = L.
- Return to IDLE.
- With no second pulse, ACK1 holds indefinitely until inta_pulse or reset.

EOI, on eoi_valid (in any state):
- Specific EOI: clear isr[eoi_level]. With eoi_rotate, rotate_update pulses with rotate_lowest = eoi_level.
- Non-specific EOI: clear the highest in-service bit. With eoi_rotate, rotate_update pulses with rotate_lowest = that level.
- Non-specific EOI with isr == 0: no-op, no rotate_update.
- Specific EOI on a clear bit: no ISR change; rotate still happens if requested.

Simultaneous events:
- EOI and INTA-set in the same cycle both apply. If they target the same bit, set wins.
- EOI-rotate and AEOI-rotate in the same cycle: the AEOI level wins rotate_lowest.

Other boundary rules:
- Outputs are registered; latency from an input event to its output is 1 cycle.
- Reset asserted mid-sequence aborts it: ISR is cleared and no vector is driven.

Decomposition:
- Shared package pic_pkg:
  - level_t (3-bit);
  - NUM_IRQ;
  - FSM state enum;
  - function prio_rank(level, lowest);
  - function highest_in_service(isr, lowest) returning {found, level}.
- One natural sub-module: pic_isr_highest, a combinational highest-rank set-bit finder. It is reused by the int_out gating and by non-specific EOI.

Test Plan:
- Fully nested (lowest=7), irr=8'b0001_0000, chosen=4, base=5'h08, two inta_pulses -> int_out=1 before the first pulse; isr=8'h10 and irr_clear=8'h10 one cycle after the first pulse; data_out=8'h44 with data_out_en=1 for one cycle after the second pulse.
- isr=8'h04 (level 2 in service), chosen=5 valid -> int_out stays 0; chosen=1 -> int_out=1 next cycle (nesting).
- Non-specific EOI with eoi_rotate, isr=8'h14, lowest=7 -> isr=8'h10; rotate_update=1 with rotate_lowest=2; then lowest=2 and chosen=3 with isr=8'h10 -> int_out=1.
- aeoi=1, rotate_aeoi=1, chosen=6, two pulses -> isr[6] set after pulse 1 and cleared after pulse 2; rotate_lowest=6; data_out={base,3'd6}.
- inta_pulse with chosen_valid=0 -> no ISR change, no irr_clear; after the second pulse data_out={base,3'd7}.
- Reset driven low while in ACK1 with isr=8'h01 -> immediately isr=0, int_out=0, data_out_en=0; FSM in IDLE after release.

Source files
------------

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and priority helpers for the 8259A-style PIC
package pic_pkg;

  localparam int NUM_IRQ = 8;

  typedef logic [2:0] level_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACK1
  } pic_state_t;

  // Rank 0 is the highest priority; rank wraps around just above the lowest level.
  function automatic level_t prio_rank(input level_t level, input level_t lowest);
    level_t r;
    r = level - lowest - 3'd1;
    return r;
  endfunction

  // Returns {found, level} of the set bit with the smallest rank.
  function automatic logic [3:0] highest_in_service(input logic [NUM_IRQ-1:0] isr_v,
                                                    input level_t lowest);
    logic [3:0] res;
    level_t     lv;
    res = 4'd0;
    for (int r = NUM_IRQ - 1; r >= 0; r--) begin
      lv = lowest + level_t'(r) + 3'd1;
      if (isr_v[lv]) res = {1'b1, lv};
    end
    return res;
  endfunction

endpackage

// File: rtl/pic_isr_highest.sv
// rtl/pic_isr_highest.sv - combinational finder of the highest-priority set ISR bit
module pic_isr_highest
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] i_isr,
  input  level_t             i_lowest,
  output logic               o_found,
  output level_t             o_level
);

  logic [3:0] w_result;

  assign w_result = highest_in_service(i_isr, i_lowest);
  assign o_found  = w_result[3];
  assign o_level  = w_result[2:0];

endmodule

// File: rtl/pic_in_service_control.sv
// rtl/pic_in_service_control.sv - INT/INTA sequencing, ISR upkeep, EOI handling and vector output
module pic_in_service_control #(
  parameter int NUM_IRQ    = 8,
  parameter int VEC_BASE_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_IRQ-1:0]    irr,
  input  logic [2:0]            chosen_interrupt,
  input  logic                  chosen_valid,
  input  logic [2:0]            lowest_priority,
  input  logic                  aeoi,
  input  logic                  rotate_aeoi,
  input  logic [VEC_BASE_W-1:0] vector_base,
  input  logic                  inta_pulse,
  input  logic                  eoi_valid,
  input  logic                  eoi_specific,
  input  logic [2:0]            eoi_level,
  input  logic                  eoi_rotate,
  output logic                  int_out,
  output logic [NUM_IRQ-1:0]    isr,
  output logic [NUM_IRQ-1:0]    irr_clear,
  output logic                  resolver_clear,
  output logic [7:0]            data_out,
  output logic                  data_out_en,
  output logic                  rotate_update,
  output logic [2:0]            rotate_lowest
);
  import pic_pkg::*;

  pic_state_t         r_state;
  level_t             r_level;
  logic               r_spurious;

  pic_state_t         w_state_next;
  level_t             w_level_next;
  logic               w_spurious_next;
  logic               w_int_next;
  logic [NUM_IRQ-1:0] w_isr_next;
  logic [NUM_IRQ-1:0] w_irr_clear_next;
  logic               w_resolver_clear_next;
  logic [7:0]         w_data_next;
  logic               w_data_en_next;
  logic               w_rotate_next;
  level_t             w_rotate_lowest_next;
  logic               w_hi_found;
  level_t             w_hi_level;
  logic               w_request;

  pic_isr_highest u_isr_highest (
    .i_isr    (isr),
    .i_lowest (lowest_priority),
    .o_found  (w_hi_found),
    .o_level  (w_hi_level)
  );

  assign w_request = chosen_valid & (|irr);

  always_comb begin
    w_state_next          = r_state;
    w_level_next          = r_level;
    w_spurious_next       = r_spurious;
    w_isr_next            = isr;
    w_irr_clear_next      = '0;
    w_resolver_clear_next = 1'b0;
    w_data_next           = 8'd0;
    w_data_en_next        = 1'b0;
    w_rotate_next         = 1'b0;
    w_rotate_lowest_next  = 3'd0;

    // An acknowledge in this cycle moves us to ACK1, so INT must fall next cycle.
    w_int_next = (r_state == ST_IDLE) && !inta_pulse && w_request &&
                 (!w_hi_found ||
                  (prio_rank(chosen_interrupt, lowest_priority) <
                   prio_rank(w_hi_level, lowest_priority)));

    // EOI clears are applied before the INTA set so a set of the same bit wins.
    if (eoi_valid) begin
      if (eoi_specific) begin
        w_isr_next[eoi_level] = 1'b0;
        if (eoi_rotate) begin
          w_rotate_next        = 1'b1;
          w_rotate_lowest_next = eoi_level;
        end
      end else if (w_hi_found) begin
        w_isr_next[w_hi_level] = 1'b0;
        if (eoi_rotate) begin
          w_rotate_next        = 1'b1;
          w_rotate_lowest_next = w_hi_level;
        end
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (inta_pulse) begin
          w_state_next = ST_ACK1;
          if (int_out) begin
            w_level_next                       = chosen_interrupt;
            w_spurious_next                    = 1'b0;
            w_isr_next[chosen_interrupt]       = 1'b1;
            w_irr_clear_next[chosen_interrupt] = 1'b1;
            w_resolver_clear_next              = 1'b1;
          end else begin
            w_level_next    = 3'd7;
            w_spurious_next = 1'b1;
          end
        end
      end
      ST_ACK1: begin
        if (inta_pulse) begin
          w_state_next   = ST_IDLE;
          w_data_next    = {vector_base, r_level};
          w_data_en_next = 1'b1;
          if (aeoi && !r_spurious) begin
            w_isr_next[r_level] = 1'b0;
            if (rotate_aeoi) begin
              w_rotate_next        = 1'b1;
              w_rotate_lowest_next = r_level;
            end
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_level        <= 3'd0;
      r_spurious     <= 1'b0;
      int_out        <= 1'b0;
      isr            <= '0;
      irr_clear      <= '0;
      resolver_clear <= 1'b0;
      data_out       <= 8'd0;
      data_out_en    <= 1'b0;
      rotate_update  <= 1'b0;
      rotate_lowest  <= 3'd0;
    end else begin
      r_state        <= w_state_next;
      r_level        <= w_level_next;
      r_spurious     <= w_spurious_next;
      int_out        <= w_int_next;
      isr            <= w_isr_next;
      irr_clear      <= w_irr_clear_next;
      resolver_clear <= w_resolver_clear_next;
      data_out       <= w_data_next;
      data_out_en    <= w_data_en_next;
      rotate_update  <= w_rotate_next;
      rotate_lowest  <= w_rotate_lowest_next;
    end
  end

endmodule
